// File: rtl/tb_mem_arb_pkg.sv
// Shared types for the testbench memory arbiter: master identifiers.
package tb_mem_arb_pkg;

  typedef enum logic {
    MST_INSTR = 1'b0,
    MST_DATA  = 1'b1
  } mst_id_e;

  localparam int NUM_MASTERS = 2;

endpackage

// File: rtl/tb_mem_arb_id_fifo.sv
// In-order FIFO of master IDs for granted-but-unanswered transactions.
// push_i and pop_i may be active together; the occupancy count then holds.
// The caller never pushes when full and never pops when empty.
module tb_mem_arb_id_fifo
  import tb_mem_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  mst_id_e          push_id_i,
  input  logic             pop_i,
  output mst_id_e          head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  mst_id_e          mem_q [DEPTH];
  mst_id_e          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state: write at the tail, advance the head, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= MST_INSTR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter sharing one pipelined req/gnt/rvalid memory port
// between instruction fetch (master 0, read-only) and data (master 1).
// Handshake: a transfer happens in the cycle where req and gnt are both high;
// req and its address/control stay stable until that cycle; every handshake
// is answered by exactly one rvalid pulse, in issue order.
module tb_mem_arbiter
  import tb_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  mst_id_e          sel;
  logic             sel_req;
  logic             handshake;
  logic             fifo_push, fifo_pop;
  logic             fifo_empty, fifo_full;
  mst_id_e          fifo_head;
  logic [CNT_W-1:0] fifo_count;

  mst_id_e last_grant_q, last_grant_d;
  logic    hold_valid_q, hold_valid_d;
  mst_id_e hold_id_q, hold_id_d;
  logic    err_q, err_d;

  // Selection: a waiting (held) request keeps the port, otherwise round robin.
  always_comb begin
    sel = MST_INSTR;
    if (hold_valid_q) begin
      sel = hold_id_q;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_grant_q == MST_INSTR) ? MST_DATA : MST_INSTR;
    end else if (data_req_i) begin
      sel = MST_DATA;
    end
    sel_req = (sel == MST_DATA) ? data_req_i : instr_req_i;
  end

  // Request forwarding, throttled on the registered outstanding count.
  always_comb begin
    mem_req_o   = sel_req && (fifo_count < CNT_W'(MAX_OUTSTANDING));
    handshake   = mem_req_o && mem_gnt_i;
    mem_addr_o  = (sel == MST_DATA) ? data_addr_i : instr_addr_i;
    mem_we_o    = (sel == MST_DATA) ? data_we_i : 1'b0;
    mem_be_o    = (sel == MST_DATA) ? data_be_i : '1;
    mem_wdata_o = (sel == MST_DATA) ? data_wdata_i : '0;
    instr_gnt_o = handshake && (sel == MST_INSTR);
    data_gnt_o  = handshake && (sel == MST_DATA);
  end

  // Response routing: rvalid goes to the oldest outstanding master only.
  always_comb begin
    fifo_push      = handshake && !fifo_full;
    fifo_pop       = mem_rvalid_i && !fifo_empty;
    instr_rvalid_o = fifo_pop && (fifo_head == MST_INSTR);
    data_rvalid_o  = fifo_pop && (fifo_head == MST_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
  end

  // Next-state for hold, round-robin pointer and sticky error.
  always_comb begin
    last_grant_d = last_grant_q;
    hold_valid_d = hold_valid_q;
    hold_id_d    = hold_id_q;
    err_d        = err_q;
    if (handshake) begin
      last_grant_d = sel;
      hold_valid_d = 1'b0;
    end else if (mem_req_o) begin
      hold_valid_d = 1'b1;
      hold_id_d    = sel;
    end
    if (mem_rvalid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= MST_INSTR;
      hold_valid_q <= 1'b0;
      hold_id_q    <= MST_INSTR;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_valid_q <= hold_valid_d;
      hold_id_q    <= hold_id_d;
      err_q        <= err_d;
    end
  end

  assign err_o = err_q;

  tb_mem_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (fifo_push),
    .push_id_i(sel),
    .pop_i    (fifo_pop),
    .head_o   (fifo_head),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full),
    .count_o  (fifo_count)
  );

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Bench for tb_mem_arbiter: directed vectors with literal expectations plus a
// queue-based reference model checked on every falling clock edge.
module tb_tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          instr_req_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = '0;
  logic [DW-1:0] data_wdata_i = '0;
  logic          data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  tb_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding masters in issue order, who won last, who is waiting for a
  // grant (-1 = nobody), and whether a stray response has been seen.
  int m_q[$];
  int m_last = 0;
  int m_wait = -1;
  bit m_err  = 1'b0;

  always @(negedge clk_i) begin
    int  who;
    bit  want, e_req, e_hs;
    if (rst_i) begin
      m_q.delete();
      m_last = 0;
      m_wait = -1;
      m_err  = 1'b0;
      chk("mdl_rst_err", err_o, 0);
    end else begin
      if (m_wait >= 0)                  who = m_wait;
      else if (instr_req_i && data_req_i) who = 1 - m_last;
      else if (data_req_i)              who = 1;
      else                              who = 0;
      want  = (who == 1) ? data_req_i : instr_req_i;
      e_req = want && (m_q.size() < MAXO);
      e_hs  = e_req && mem_gnt_i;
      chk("mdl_mem_req",   mem_req_o,   e_req);
      chk("mdl_instr_gnt", instr_gnt_o, e_hs && who == 0);
      chk("mdl_data_gnt",  data_gnt_o,  e_hs && who == 1);
      if (e_req) begin
        chk("mdl_addr",  mem_addr_o,  (who == 1) ? data_addr_i : instr_addr_i);
        chk("mdl_we",    mem_we_o,    (who == 1) ? data_we_i : 1'b0);
        chk("mdl_be",    mem_be_o,    (who == 1) ? data_be_i : 4'hF);
        if (who == 1) chk("mdl_wdata", mem_wdata_o, data_wdata_i);
      end
      chk("mdl_instr_rv", instr_rvalid_o,
          mem_rvalid_i && m_q.size() > 0 && m_q[0] == 0);
      chk("mdl_data_rv", data_rvalid_o,
          mem_rvalid_i && m_q.size() > 0 && m_q[0] == 1);
      chk("mdl_err", err_o, m_err);
      if (instr_rvalid_o || data_rvalid_o) begin
        chk("mdl_irdata", instr_rdata_o, mem_rdata_i);
        chk("mdl_drdata", data_rdata_o,  mem_rdata_i);
      end
      // Commit what the coming rising edge will do.
      if (mem_rvalid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else                m_err = 1'b1;
      end
      if (e_hs) begin
        m_q.push_back(who);
        m_last = who;
        m_wait = -1;
      end else if (e_req) begin
        m_wait = who;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input bit ir, input logic [AW-1:0] ia,
                        input bit dr, input logic [AW-1:0] da, input bit dwe,
                        input logic [3:0] dbe, input logic [DW-1:0] dwd,
                        input bit g, input bit rv, input logic [DW-1:0] rd);
    instr_req_i  = ir;  instr_addr_i = ia;
    data_req_i   = dr;  data_addr_i  = da;
    data_we_i    = dwe; data_be_i    = dbe; data_wdata_i = dwd;
    mem_gnt_i    = g;   mem_rvalid_i = rv;  mem_rdata_i  = rd;
  endtask

  task automatic idle();
    set_in(0, '0, 0, '0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    cyc(); cyc();
    #2;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_gnts",    {instr_gnt_o, data_gnt_o}, 0);
    chk("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    chk("rst_err",     err_o, 0);
    rst_i = 1'b0;

    // Single data write with same-cycle grant, answered next cycle.
    cyc(); set_in(0, '0, 1, 32'h100, 1, 4'hF, 32'hDEADBEEF, 1, 0, '0); #2;
    chk("wr_data_gnt", data_gnt_o, 1);
    chk("wr_we",       mem_we_o, 1);
    chk("wr_addr",     mem_addr_o, 32'h100);
    chk("wr_wdata",    mem_wdata_o, 32'hDEADBEEF);
    cyc(); set_in(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h0); #2;
    chk("wr_data_rv",  data_rvalid_o, 1);
    chk("wr_instr_rv", instr_rvalid_o, 0);

    // Both request after reset, memory always grants and answers next cycle.
    cyc(); do_reset();
    set_in(1, 32'h40, 1, 32'h200, 0, 4'h3, '0, 1, 0, '0); #2;
    chk("rr0_data_gnt", {instr_gnt_o, data_gnt_o}, 2'b01);
    chk("rr0_addr",     mem_addr_o, 32'h200);
    cyc(); set_in(1, 32'h40, 1, 32'h200, 0, 4'h3, '0, 1, 1, 32'h11); #2;
    chk("rr1_instr_gnt", {instr_gnt_o, data_gnt_o}, 2'b10);
    chk("rr1_addr",      mem_addr_o, 32'h40);
    chk("rr1_be",        mem_be_o, 4'hF);
    chk("rr1_data_rv",   {instr_rvalid_o, data_rvalid_o}, 2'b01);
    cyc(); set_in(1, 32'h40, 1, 32'h200, 0, 4'h3, '0, 1, 1, 32'h22); #2;
    chk("rr2_data_gnt", {instr_gnt_o, data_gnt_o}, 2'b01);
    chk("rr2_instr_rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    chk("rr2_rdata",    instr_rdata_o, 32'h22);
    cyc(); set_in(1, 32'h40, 1, 32'h200, 0, 4'h3, '0, 1, 1, 32'h33); #2;
    chk("rr3_instr_gnt", {instr_gnt_o, data_gnt_o}, 2'b10);
    chk("rr3_data_rv",   {instr_rvalid_o, data_rvalid_o}, 2'b01);
    cyc(); set_in(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h44); #2;
    chk("rr4_instr_rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    chk("rr4_no_req",   mem_req_o, 0);

    // Grant withheld: instr address held, data arrives while instr waits.
    cyc(); set_in(1, 32'h80, 0, 32'h300, 1, 4'h1, 32'h5, 0, 0, '0); #2;
    chk("hold0_addr", mem_addr_o, 32'h80);
    cyc(); set_in(1, 32'h80, 1, 32'h300, 1, 4'h1, 32'h5, 0, 0, '0); #2;
    chk("hold1_addr", mem_addr_o, 32'h80);
    chk("hold1_we",   mem_we_o, 0);
    cyc(); set_in(1, 32'h80, 1, 32'h300, 1, 4'h1, 32'h5, 0, 0, '0); #2;
    chk("hold2_addr", mem_addr_o, 32'h80);
    cyc(); set_in(1, 32'h80, 1, 32'h300, 1, 4'h1, 32'h5, 1, 0, '0); #2;
    chk("hold3_addr", mem_addr_o, 32'h80);
    chk("hold3_gnt",  {instr_gnt_o, data_gnt_o}, 2'b10);
    cyc(); set_in(0, '0, 1, 32'h300, 1, 4'h1, 32'h5, 1, 0, '0); #2;
    chk("hold4_gnt",  {instr_gnt_o, data_gnt_o}, 2'b01);
    chk("hold4_addr", mem_addr_o, 32'h300);
    cyc(); set_in(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h66); #2;
    chk("hold5_rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    cyc(); set_in(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h77); #2;
    chk("hold6_rv", {instr_rvalid_o, data_rvalid_o}, 2'b01);

    // Throttle at MAX_OUTSTANDING; a same-cycle response does not bypass.
    cyc(); set_in(1, 32'h10, 1, 32'h20, 0, 4'hF, '0, 1, 0, '0); #2;
    chk("thr0_gnt", {instr_gnt_o, data_gnt_o}, 2'b10);
    cyc(); set_in(1, 32'h10, 1, 32'h20, 0, 4'hF, '0, 1, 0, '0); #2;
    chk("thr1_gnt", {instr_gnt_o, data_gnt_o}, 2'b01);
    cyc(); set_in(1, 32'h10, 1, 32'h20, 0, 4'hF, '0, 1, 0, '0); #2;
    chk("thr2_req", mem_req_o, 0);
    chk("thr2_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
    cyc(); set_in(1, 32'h10, 1, 32'h20, 0, 4'hF, '0, 1, 1, 32'hA1); #2;
    chk("thr3_req", mem_req_o, 0);
    chk("thr3_rv",  {instr_rvalid_o, data_rvalid_o}, 2'b10);
    cyc(); set_in(1, 32'h10, 1, 32'h20, 0, 4'hF, '0, 1, 0, '0); #2;
    chk("thr4_req", mem_req_o, 1);
    chk("thr4_gnt", {instr_gnt_o, data_gnt_o}, 2'b10);
    cyc(); set_in(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'hA2); #2;
    chk("thr5_rv", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    cyc(); set_in(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'hA3); #2;
    chk("thr6_rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);

    // Stray response with nothing outstanding.
    cyc(); set_in(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'hBB); #2;
    chk("spur_rv",     {instr_rvalid_o, data_rvalid_o}, 2'b00);
    chk("spur_err_0",  err_o, 0);
    cyc(); idle(); #2;
    chk("spur_err_1",  err_o, 1);
    cyc(); #2;
    chk("spur_err_2",  err_o, 1);

    // Reset in the middle of traffic: one outstanding, one waiting.
    cyc(); set_in(0, '0, 1, 32'h400, 0, 4'hF, '0, 1, 0, '0);
    cyc(); set_in(1, 32'h500, 0, '0, 0, '0, '0, 0, 0, '0); #2;
    chk("mid_hold_addr", mem_addr_o, 32'h500);
    idle();
    rst_i = 1'b1;
    #1;
    chk("mid_rst_err",  err_o, 0);
    chk("mid_rst_req",  mem_req_o, 0);
    chk("mid_rst_outs", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}, 0);
    cyc(); rst_i = 1'b0;
    set_in(0, '0, 1, 32'h600, 1, 4'h2, 32'h9, 0, 0, '0); #2;
    chk("post_rst_addr", mem_addr_o, 32'h600);
    chk("post_rst_we",   mem_we_o, 1);
    cyc(); set_in(0, '0, 1, 32'h600, 1, 4'h2, 32'h9, 1, 1, 32'hCC); #2;
    chk("post_rst_gnt",  data_gnt_o, 1);
    chk("post_rst_rv",   {instr_rvalid_o, data_rvalid_o}, 2'b00);
    cyc(); idle(); #2;
    chk("post_rst_err",  err_o, 1);
    cyc(); set_in(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'hDD); #2;
    chk("post_rst_late_rv", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    cyc(); idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
